// File: rtl/accel_dispatch_if.sv
// Decode/engine-side bundle for accel_dispatch.
// Requests and engine done arrive from the master; status comes back.
interface accel_dispatch_if #(
  parameter int DEPTH = 4
);
  logic                         H_int;
  logic                         E_int;
  logic                         D_int;
  logic [10:0]                  index;
  logic                         eng_done;
  logic                         err_clr;
  logic                         eng_start;
  logic [1:0]                   eng_op;
  logic [10:0]                  eng_index;
  logic                         H_done;
  logic                         E_done;
  logic                         D_done;
  logic                         busy;
  logic                         full;
  logic [$clog2(DEPTH+1)-1:0]   q_count;
  logic                         ovf_err;
  logic                         timeout_err;

  modport master (
    output H_int, E_int, D_int, index, eng_done, err_clr,
    input  eng_start, eng_op, eng_index, H_done, E_done, D_done,
    input  busy, full, q_count, ovf_err, timeout_err
  );

  modport slave (
    input  H_int, E_int, D_int, index, eng_done, err_clr,
    output eng_start, eng_op, eng_index, H_done, E_done, D_done,
    output busy, full, q_count, ovf_err, timeout_err
  );
endinterface

// File: rtl/accel_dispatch.sv
// Queues hash/encrypt/decrypt requests from decode and runs them
// one at a time on the crypto engine, returning per-op done pulses.
module accel_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input logic             clk,
  input logic             rst_n,
  accel_dispatch_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, START, WAIT, DONE
  } state_t;

  state_t        state;
  logic [1:0]    fifo_op  [DEPTH];
  logic [10:0]   fifo_idx [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tcnt;
  logic [1:0]    op_q;
  logic [10:0]   idx_q;
  logic          start_q;
  logic          h_q, e_q, d_q;
  logic          ovf_q, tmo_q;

  logic          req, multi, full_c;
  logic          pop, push, drop;
  logic          fin, tmo_hit;
  logic [1:0]    req_op;

  assign req    = io.H_int | io.E_int | io.D_int;
  assign multi  = (io.H_int & io.E_int) | (io.H_int & io.D_int)
                | (io.E_int & io.D_int);
  assign full_c = (count == CW'(DEPTH));
  assign pop    = (state == IDLE) && (count != '0);
  // a full FIFO still accepts when the head leaves this cycle
  assign push   = req && (!full_c || pop);
  assign drop   = multi || (req && !push);
  assign fin    = (state == WAIT) && (io.eng_done || tcnt == LAST);
  assign tmo_hit = (state == WAIT) && !io.eng_done && (tcnt == LAST);

  always_comb begin
    req_op = 2'b00;
    priority case (1'b1)
      io.H_int: req_op = 2'b01;
      io.E_int: req_op = 2'b10;
      io.D_int: req_op = 2'b11;
      default:  req_op = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tcnt    <= '0;
      op_q    <= 2'b00;
      idx_q   <= '0;
      start_q <= 1'b0;
      h_q     <= 1'b0;
      e_q     <= 1'b0;
      d_q     <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_op[i]  <= 2'b00;
        fifo_idx[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_op[wr_ptr]  <= req_op;
        fifo_idx[wr_ptr] <= io.index;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count   <= count + CW'(push) - CW'(pop);
      ovf_q   <= drop | (ovf_q & ~io.err_clr);
      tmo_q   <= tmo_hit | (tmo_q & ~io.err_clr);
      start_q <= 1'b0;
      h_q     <= fin && (op_q == 2'b01);
      e_q     <= fin && (op_q == 2'b10);
      d_q     <= fin && (op_q == 2'b11);
      unique case (state)
        IDLE: if (pop) begin
          op_q    <= fifo_op[rd_ptr];
          idx_q   <= fifo_idx[rd_ptr];
          start_q <= 1'b1;
          state   <= START;
        end
        START: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (fin) state <= DONE;
          else     tcnt  <= tcnt + 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign io.eng_start   = start_q;
  assign io.eng_op      = op_q;
  assign io.eng_index   = idx_q;
  assign io.H_done      = h_q;
  assign io.E_done      = e_q;
  assign io.D_done      = d_q;
  assign io.busy        = (state != IDLE) || (count != '0);
  assign io.full        = full_c;
  assign io.q_count     = count;
  assign io.ovf_err     = ovf_q;
  assign io.timeout_err = tmo_q;
endmodule

// File: tb/tb_accel_dispatch.sv
// Directed bench for accel_dispatch (DEPTH=4, TIMEOUT=16).
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_accel_dispatch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  accel_dispatch_if #(.DEPTH(4)) io ();

  accel_dispatch #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return 32'({io.eng_start, io.eng_op, io.eng_index, io.H_done,
                io.E_done, io.D_done, io.busy, io.full, io.q_count,
                io.ovf_err, io.timeout_err});
  endfunction

  function automatic logic [31:0] hot(input logic [1:0] op);
    return (op == 2'b01) ? 32'h4 : (op == 2'b10) ? 32'h2 : 32'h1;
  endfunction

  // raise eng_done now; next cycle is DONE, the one after is IDLE
  task automatic finish_op(input string tag, input logic [1:0] op,
                           input logic [10:0] idx);
    io.eng_done = 1'b1;
    tick();
    io.eng_done = 1'b0;
    chk({tag, "_done"}, 32'({io.H_done, io.E_done, io.D_done}), hot(op));
    chk({tag, "_hold_op"}, 32'(io.eng_op), 32'(op));
    chk({tag, "_hold_idx"}, 32'(io.eng_index), 32'(idx));
    tick();
    chk({tag, "_done_off"}, 32'({io.H_done, io.E_done, io.D_done}), 32'h0);
  endtask

  // entered in the START cycle; eng_done raised w cycles after start
  task automatic do_op(input string tag, input logic [1:0] op,
                       input logic [10:0] idx, input int w);
    chk({tag, "_start"}, 32'(io.eng_start), 32'h1);
    chk({tag, "_op"}, 32'(io.eng_op), 32'(op));
    chk({tag, "_idx"}, 32'(io.eng_index), 32'(idx));
    tick();
    chk({tag, "_start_off"}, 32'(io.eng_start), 32'h0);
    repeat (w - 1) tick();
    finish_op(tag, op, idx);
  endtask

  task automatic req(input logic h, input logic e, input logic d,
                     input logic [10:0] idx);
    io.H_int = h;
    io.E_int = e;
    io.D_int = d;
    io.index = idx;
  endtask

  initial begin
    logic acc;
    req(0, 0, 0, '0);
    io.eng_done = 1'b0;
    io.err_clr  = 1'b0;
    #1;
    chk("reset_outs", all_out(), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_outs", all_out(), 32'h0);

    // single encrypt
    req(0, 1, 0, 11'h2A5);
    tick();
    req(0, 0, 0, '0);
    chk("t1_qcnt", 32'(io.q_count), 32'd1);
    chk("t1_busy", 32'(io.busy), 32'h1);
    tick();
    do_op("t1", 2'b10, 11'h2A5, 5);
    chk("t1_idle", 32'(io.busy), 32'h0);

    // H, E, D back to back
    req(1, 0, 0, 11'h001);
    tick();
    req(0, 1, 0, 11'h002);
    tick();
    chk("t2_h_start", 32'(io.eng_start), 32'h1);
    chk("t2_h_op", 32'(io.eng_op), 32'h1);
    req(0, 0, 1, 11'h003);
    tick();
    req(0, 0, 0, '0);
    chk("t2_qpeak", 32'(io.q_count), 32'd2);
    tick();
    tick();
    finish_op("t2_h", 2'b01, 11'h001);
    tick();
    do_op("t2_e", 2'b10, 11'h002, 3);
    tick();
    do_op("t2_d", 2'b11, 11'h003, 3);
    chk("t2_qend", 32'(io.q_count), 32'd0);
    chk("t2_busy", 32'(io.busy), 32'h0);

    // overflow with a stalled engine
    req(1, 0, 0, 11'h100);
    tick();
    req(0, 1, 0, 11'h101);
    tick();
    req(0, 0, 1, 11'h102);
    tick();
    req(1, 0, 0, 11'h103);
    tick();
    req(0, 1, 0, 11'h104);
    tick();
    chk("t3_full", 32'(io.full), 32'h1);
    chk("t3_noovf", 32'(io.ovf_err), 32'h0);
    req(0, 0, 1, 11'h105);
    tick();
    req(0, 0, 0, '0);
    chk("t3_qcnt", 32'(io.q_count), 32'd4);
    chk("t3_ovf", 32'(io.ovf_err), 32'h1);
    finish_op("t3_0", 2'b01, 11'h100);
    tick();
    do_op("t3_1", 2'b10, 11'h101, 2);
    tick();
    do_op("t3_2", 2'b11, 11'h102, 2);
    tick();
    do_op("t3_3", 2'b01, 11'h103, 2);
    tick();
    do_op("t3_4", 2'b10, 11'h104, 2);
    acc = 1'b0;
    repeat (4) begin
      tick();
      acc = acc | io.eng_start;
    end
    chk("t3_no_sixth", 32'(acc), 32'h0);
    chk("t3_qzero", 32'(io.q_count), 32'd0);

    // simultaneous H and D
    io.err_clr = 1'b1;
    tick();
    io.err_clr = 1'b0;
    chk("t4_clr0", 32'(io.ovf_err), 32'h0);
    req(1, 0, 1, 11'h7FF);
    tick();
    req(0, 0, 0, '0);
    chk("t4_q1", 32'(io.q_count), 32'd1);
    chk("t4_ovf", 32'(io.ovf_err), 32'h1);
    tick();
    do_op("t4", 2'b01, 11'h7FF, 2);
    io.err_clr = 1'b1;
    tick();
    chk("t4_clr", 32'(io.ovf_err), 32'h0);
    req(1, 1, 0, 11'h011);
    tick();
    io.err_clr = 1'b0;
    req(0, 0, 0, '0);
    chk("t4_setwins", 32'(io.ovf_err), 32'h1);
    tick();
    do_op("t4b", 2'b01, 11'h011, 2);
    io.err_clr = 1'b1;
    tick();
    io.err_clr = 1'b0;

    // timeout
    req(0, 1, 0, 11'h055);
    tick();
    req(0, 0, 0, '0);
    tick();
    chk("t5_start", 32'(io.eng_start), 32'h1);
    repeat (16) tick();
    chk("t5_not_yet", 32'({io.E_done, io.timeout_err}), 32'h0);
    tick();
    chk("t5_done", 32'({io.H_done, io.E_done, io.D_done}), 32'h2);
    chk("t5_tmo", 32'(io.timeout_err), 32'h1);
    tick();
    req(0, 0, 1, 11'h3C3);
    tick();
    req(0, 0, 0, '0);
    tick();
    do_op("t5_next", 2'b11, 11'h3C3, 3);
    chk("t5_sticky", 32'(io.timeout_err), 32'h1);

    // reset in WAIT with two queued
    req(1, 0, 0, 11'h001);
    tick();
    req(0, 1, 0, 11'h002);
    tick();
    req(0, 0, 1, 11'h003);
    tick();
    req(0, 0, 0, '0);
    chk("t6_q2", 32'(io.q_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", all_out(), 32'h0);
    tick();
    rst_n = 1'b1;
    acc = 1'b0;
    repeat (5) begin
      tick();
      acc = acc | io.eng_start | io.H_done | io.E_done | io.D_done;
    end
    chk("t6_quiet", 32'(acc), 32'h0);
    req(1, 0, 0, 11'h05A);
    tick();
    req(0, 0, 0, '0);
    tick();
    do_op("t6_new", 2'b01, 11'h05A, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
